pipo_register_write_arbiter: RTL
================================

# pipo_register_write_arbiter

Round-robin arbiter sharing one 4-bit parallel-in/parallel-out storage register among `NUM_REQ` requesters. Each requester raises `req` with its 4-bit word. The arbiter grants one requester at a time, loads that word into the register, and acknowledges the write with a single-cycle pulse. It sits between several producer blocks and the single shared 4-bit register they all update. A synchronous clear request, with priority over writes, zeroes the register through the same sequencing.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `clk`  in  1: rising-edge clock.
- `clear_n`  in  1: asynchronous, active-low reset of the entire block.
- `clear_req`  in  1: synchronous request to zero the register; has priority over all `req`.
- `req`  in  `NUM_REQ`: per-requester write request, level-held until `ack`.
- `data_in`  in  `4*NUM_REQ`: requester i's word is `data_in[4*i+3:4*i]`.
- `grant`  out  `NUM_REQ`: one-hot, identifies the requester being serviced.
- `ack`  out  1: one-cycle pulse; the register has been updated by the granted requester or by the clear.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `reg_out`  out  4: current contents of the shared register.

## Operation
- Reset value of every output is 0: `grant`, `ack`, `busy`, `reg_out`. After reset the round-robin pointer gives requester 0 first priority.
- FSM states: IDLE, LOAD, DONE.
- **IDLE**
  - If `clear_req` is high: go to LOAD with `grant` = 0 and the clear flag set.
  - Else, if any `req` bit is high: select the winner as the first set bit found searching upward, with wrap, from the index one above the last winner. Register `grant` with the winner's one-hot code and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - On the exiting edge, the register loads 4'b0000 if the clear flag is set; otherwise it loads the granted requester's slice.
  - The pointer is updated to the winner. A clear does not move the pointer.
  - Go to DONE.
- **DONE**
  - `ack` = 1, `grant` = 0.
  - Go to IDLE.
- `req` and `data_in` are not sampled in LOAD or DONE. Requests arriving during those states wait for IDLE.
- A requester must hold its `data_in` slice stable while its `grant` bit is high. If its `req` drops during LOAD, the write still completes and is still acknowledged.
- A requester must deassert `req` in the cycle after it sees `ack`. If `req` is still high in the following IDLE cycle, it is treated as a new request, at lowest priority.
- If `clear_req` and any `req` are high together in IDLE, the clear is serviced first and the requests wait.
- Asserting `clear_n` low at any point, including mid-transaction, immediately forces IDLE, zeroes the register, and resets the pointer. The interrupted transaction produces no `ack`.

## Timing
- Request sampled at edge T0 (in IDLE) → `grant` and `busy` high during cycle T0..T1.
- `reg_out` shows the new value from edge T1.
- `ack` is high during T1..T2.
- FSM is back in IDLE at T2; the next grant can appear from edge T2.
- Sustained throughput: one write per 3 cycles.
- Worst-case wait for a continuously requesting client: `NUM_REQ` transactions, with no clears in between.
- `grant` and `ack` are never high in the same cycle.

## Configuration
- `PIPO_ARB_WRITE_COUNT_EN` defined:
  - Adds output `write_count [7:0]`, reset 0.
  - Increments on every `ack` caused by a requester write; clears do not count.
  - Saturates at 8'hFF; a clear request does not reset it.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `pipo_arb_pkg` holds:
  - data width constant `PIPO_WIDTH` = 4;
  - state encodings IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
  - counter width constant `PIPO_CNT_WIDTH` = 8.
- One sub-module, `pipo_register_4_bit`:
  - ports: `clk`, `clear_n` (asynchronous reset), `load`, `sync_clear`, `d[3:0]`, `q[3:0]`;
  - `sync_clear` has priority over `load`.
- The arbiter contains the FSM, the round-robin pointer and the data mux, and drives that sub-module.

## Test plan
- Reset, then `req`=4'b0001, word0=4'hD → `grant`=0001 one cycle later, `reg_out`=4'hD on the next edge, `ack` pulse of exactly one cycle.
- `req`=4'b1111 held continuously, words 1,2,3,4 → grants in order 0001, 0010, 0100, 1000, 0001 at 3-cycle spacing; `reg_out` sequence 1,2,3,4,1.
- `reg_out`=4'hB, then `clear_req` and `req`=4'b0010 raised in the same cycle → first `ack` with `reg_out`=0 and `grant` never high; requester 1's write follows 3 cycles later.
- `clear_n` pulsed low during LOAD of word 4'h6 → `reg_out`=0, `grant`=0, no `ack`; with `req`=4'b1010 afterwards, requester 1 wins.
- `req` dropped during LOAD → write still lands and `ack` still pulses.
- With `PIPO_ARB_WRITE_COUNT_EN`: 300 writes → `write_count` = 8'hFF, and unchanged by a subsequent clear.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// Shared constants and FSM encoding for the PIPO register write arbiter.
package pipo_arb_pkg;

    localparam int PIPO_WIDTH     = 4;
    localparam int PIPO_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } pipo_state_e;

endpackage : pipo_arb_pkg

// File: rtl/pipo_register_4_bit.sv
// 4-bit parallel-in/parallel-out storage register; sync_clear wins over load.
module pipo_register_4_bit
    import pipo_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  load,
    input  logic                  sync_clear,
    input  logic [PIPO_WIDTH-1:0] d,
    output logic [PIPO_WIDTH-1:0] q
);

    logic [PIPO_WIDTH-1:0] q_q;
    logic [PIPO_WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (sync_clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : pipo_register_4_bit

// File: rtl/pipo_register_write_arbiter.sv
// Round-robin arbiter sharing one 4-bit PIPO register among NUM_REQ writers.
// Optional write counter output enabled by defining PIPO_ARB_WRITE_COUNT_EN.
module pipo_register_write_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic                          clear_req,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [PIPO_WIDTH*NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          ack,
    output logic                          busy,
    output logic [PIPO_WIDTH-1:0]         reg_out,
    output pipo_state_e                   state_dbg
`ifdef PIPO_ARB_WRITE_COUNT_EN
    ,
    output logic [PIPO_CNT_WIDTH-1:0]     write_count
`endif
);

    // Handshake: req is level-held and sampled only in IDLE; grant is high for
    // the LOAD cycle, ack pulses one cycle in DONE, and the requester drops req
    // the cycle after ack or it is re-arbitrated at lowest priority.

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    pipo_state_e               state_q, state_d;
    logic [IDX_W-1:0]          ptr_q;
    logic [IDX_W-1:0]          win_q;
    logic [IDX_W-1:0]          win_d;
    logic [NUM_REQ-1:0]        grant_q;
    logic                      clr_flag_q;
    logic                      req_found;
    logic                      reg_load;
    logic                      reg_clear;
    logic [PIPO_WIDTH-1:0]     words [NUM_REQ];
    logic [PIPO_WIDTH-1:0]     mux_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = data_in[g*PIPO_WIDTH +: PIPO_WIDTH];
    end

    assign mux_data = words[win_q];

    // Search starts one above the last winner and wraps.
    always_comb begin : arb_search
        int               idx;
        logic [IDX_W-1:0] cand;
        req_found = 1'b0;
        win_d     = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!req_found && req[cand]) begin
                req_found = 1'b1;
                win_d     = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req || req_found) begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack       = (state_q == DONE);
        busy      = (state_q != IDLE);
        reg_load  = (state_q == LOAD) && !clr_flag_q;
        reg_clear = (state_q == LOAD) && clr_flag_q;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            grant_q    <= '0;
            win_q      <= '0;
            clr_flag_q <= 1'b0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        clr_flag_q <= 1'b1;
                        grant_q    <= '0;
                    end else if (req_found) begin
                        clr_flag_q <= 1'b0;
                        grant_q    <= NUM_REQ'(1) << win_d;
                        win_q      <= win_d;
                    end
                end
                LOAD: begin
                    grant_q <= '0;
                    // A clear leaves the fairness pointer where it was.
                    if (!clr_flag_q) begin
                        ptr_q <= win_q;
                    end
                end
                DONE: begin
                    clr_flag_q <= 1'b0;
                end
                default: begin
                    grant_q <= '0;
                end
            endcase
        end
    end

    pipo_register_4_bit u_reg (
        .clk        (clk),
        .clear_n    (clear_n),
        .load       (reg_load),
        .sync_clear (reg_clear),
        .d          (mux_data),
        .q          (reg_out)
    );

    assign grant     = grant_q;
    assign state_dbg = state_q;

`ifdef PIPO_ARB_WRITE_COUNT_EN
    logic [PIPO_CNT_WIDTH-1:0] wr_cnt_q;

    // Counts requester acks only; saturates and survives clear requests.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_cnt_q <= '0;
        end else if ((state_q == DONE) && !clr_flag_q && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    assign write_count = wr_cnt_q;
`endif

endmodule : pipo_register_write_arbiter
